fetch_basic: RTL and testbench

//  In-order, single-issue fetch stage; feeds the decoder over the F->D handshake.

---
 rtl/fetch_basic_pkg.sv | 5 +
 rtl/fetch_basic_if.sv | 28 ++
 rtl/fetch_basic_pc_queue.sv | 49 ++++
 rtl/fetch_basic.sv | 130 +++++++++++++
 tb/tb_fetch_basic.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/fetch_basic_pkg.sv
// Shared ISA constants for the fetch stage: reset PC and sequential PC stride.
package fetch_basic_pkg;
  localparam logic [31:0] c_rst_addr = 32'h0000_0200;
  localparam int unsigned c_pc_incr  = 32'd4;
endpackage

// File: rtl/fetch_basic_if.sv
// Fetch-stage handshake bundle: memory request/response, F->D delivery and redirect.
interface fetch_basic_if #(
  parameter int p_addr_bits = 32,
  parameter int p_inst_bits = 32
);
  logic                   mem_req_val;
  logic                   mem_req_rdy;
  logic [p_addr_bits-1:0] mem_req_addr;
  logic                   mem_resp_val;
  logic                   mem_resp_rdy;
  logic [p_inst_bits-1:0] mem_resp_data;
  logic                   d_val;
  logic                   d_rdy;
  logic [p_inst_bits-1:0] d_inst;
  logic [p_addr_bits-1:0] d_pc;
  logic                   squash;
  logic [p_addr_bits-1:0] branch_target;

  modport master (
    output mem_req_val, mem_req_addr, mem_resp_rdy, d_val, d_inst, d_pc,
    input  mem_req_rdy, mem_resp_val, mem_resp_data, d_rdy, squash, branch_target
  );

  modport slave (
    input  mem_req_val, mem_req_addr, mem_resp_rdy, d_val, d_inst, d_pc,
    output mem_req_rdy, mem_resp_val, mem_resp_data, d_rdy, squash, branch_target
  );
endinterface

// File: rtl/fetch_basic_pc_queue.sv
// Small FIFO holding the PCs of live memory requests; clear wins over a same-cycle push.
module fetch_pc_queue #(
  parameter type t_entry = logic [31:0],
  parameter int  p_depth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  t_entry                   push_data,
  input  logic                     pop,
  input  logic                     clear,
  output t_entry                   head,
  output logic [$clog2(p_depth):0] count
);
  localparam int p_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;

  t_entry                   mem_r [p_depth];
  logic [p_ptr_bits-1:0]    rd_ptr_r;
  logic [p_ptr_bits-1:0]    wr_ptr_r;
  logic [$clog2(p_depth):0] count_r;

  function automatic logic [p_ptr_bits-1:0] ptr_inc(input logic [p_ptr_bits-1:0] p);
    if (p == p_ptr_bits'(p_depth - 1)) return '0;
    else return p + p_ptr_bits'(1);
  endfunction

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (push && !pop) count_r <= count_r + ($clog2(p_depth)+1)'(1);
      else if (pop && !push) count_r <= count_r - ($clog2(p_depth)+1)'(1);
      else count_r <= count_r;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
endmodule

// File: rtl/fetch_basic.sv
// In-order single-issue fetch: sequential PCs, in-order response pairing,
// and squash redirect that discards every response still in flight.
module fetch_basic_checker #(
  parameter int p_max_in_flight = 2
) (
  input logic                             clk,
  input logic                             rst,
  input logic                             resp_val,
  input logic [$clog2(p_max_in_flight):0] q_count,
  input logic [$clog2(p_max_in_flight):0] drop_cnt
);
  // Responses need a matching request; occupancy never exceeds the window.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(resp_val && q_count == '0 && drop_cnt == '0))
        else $error("fetch_basic: response with nothing in flight");
      assert (({1'b0, q_count} + {1'b0, drop_cnt}) <= ($clog2(p_max_in_flight)+2)'(p_max_in_flight))
        else $error("fetch_basic: in-flight count exceeds limit");
    end
  end
endmodule

module fetch_basic
  import fetch_basic_pkg::*;
#(
  parameter int               p_addr_bits     = 32,
  parameter int               p_inst_bits     = 32,
  parameter logic [31:0]      p_rst_addr      = c_rst_addr,
  parameter int               p_max_in_flight = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_basic_if.master bus
);
  localparam int p_cnt_bits = $clog2(p_max_in_flight) + 1;

  logic [p_addr_bits-1:0] pc_r;
  logic [p_cnt_bits-1:0]  drop_cnt_r;
  logic [p_cnt_bits-1:0]  q_count_s;
  logic [p_addr_bits-1:0] q_head_s;
  logic [p_cnt_bits:0]    live_s;
  logic                   dropping_s;
  logic                   req_val_s;
  logic                   req_xfer_s;
  logic                   resp_rdy_s;
  logic                   resp_xfer_s;
  logic                   d_val_s;
  logic                   pop_s;

  // Issue, response and squash muxing; squash overrides everything but reset.
  always_comb begin
    live_s     = {1'b0, q_count_s} + {1'b0, drop_cnt_r};
    dropping_s = (drop_cnt_r != '0);
    req_val_s  = 1'b0;
    resp_rdy_s = 1'b0;
    d_val_s    = 1'b0;
    if (rst) begin
      req_val_s  = 1'b0;
    end else if (bus.squash) begin
      resp_rdy_s = 1'b1;
    end else begin
      req_val_s = (live_s < (p_cnt_bits+1)'(p_max_in_flight));
      if (dropping_s) begin
        resp_rdy_s = 1'b1;
      end else begin
        d_val_s    = bus.mem_resp_val;
        resp_rdy_s = bus.d_rdy;
      end
    end
    req_xfer_s  = req_val_s & bus.mem_req_rdy;
    resp_xfer_s = resp_rdy_s & bus.mem_resp_val;
    pop_s       = resp_xfer_s & ~dropping_s & ~bus.squash;
  end

  // PC register and count of stale responses still owed by memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= p_addr_bits'(p_rst_addr);
      drop_cnt_r <= '0;
    end else if (bus.squash) begin
      pc_r       <= bus.branch_target;
      drop_cnt_r <= drop_cnt_r + q_count_s - p_cnt_bits'(resp_xfer_s);
    end else begin
      if (req_xfer_s) pc_r <= pc_r + p_addr_bits'(c_pc_incr);
      if (resp_xfer_s && dropping_s) drop_cnt_r <= drop_cnt_r - p_cnt_bits'(1);
    end
  end

  fetch_pc_queue #(
    .t_entry (logic [p_addr_bits-1:0]),
    .p_depth (p_max_in_flight)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (req_xfer_s),
    .push_data (pc_r),
    .pop       (pop_s),
    .clear     (bus.squash),
    .head      (q_head_s),
    .count     (q_count_s)
  );

  assign bus.mem_req_val  = req_val_s;
  assign bus.mem_req_addr = pc_r;
  assign bus.mem_resp_rdy = resp_rdy_s;
  assign bus.d_val        = d_val_s;
  assign bus.d_inst       = bus.mem_resp_data;
  assign bus.d_pc         = q_head_s;

`ifndef SYNTHESIS
  fetch_basic_checker #(.p_max_in_flight(p_max_in_flight)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .resp_val (bus.mem_resp_val),
    .q_count  (q_count_s),
    .drop_cnt (drop_cnt_r)
  );

  function automatic string line_trace();
    string s;
    if (bus.d_val && bus.d_rdy) begin
      s = $sformatf("%h", bus.d_pc);
    end else begin
      s = "";
      for (int i = 0; i < (p_addr_bits + 3) / 4; i++) s = {s, " "};
    end
    return s;
  endfunction
`endif
endmodule

// File: tb/tb_fetch_basic.sv
// Randomized bench for fetch_basic against an in-flight request model.
module tb_fetch_basic;
  import fetch_basic_pkg::*;

  localparam int c_max = 2;

  typedef struct {
    logic [31:0] addr;
    bit          live;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] exp_pc;
  req_t        outst[$];
  logic [31:0] mem_q[$];
  bit          hold;

  always #5 clk = ~clk;

  fetch_basic_if #(.p_addr_bits(32), .p_inst_bits(32)) bus ();

  fetch_basic #(.p_max_in_flight(c_max)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit sq, input logic [31:0] tgt,
                      input bit drdy, input bit qrdy, input int unsigned resp_pct);
    bit has_head, head_live, e_req, e_rdy, e_dval, e_rxfer;
    @(negedge clk);
    rst               = r;
    bus.squash        = sq;
    bus.branch_target = tgt;
    bus.d_rdy         = drdy;
    bus.mem_req_rdy   = qrdy;
    if (!r && mem_q.size() != 0 && (hold || $urandom_range(0, 99) < resp_pct)) begin
      bus.mem_resp_val  = 1'b1;
      bus.mem_resp_data = mem_fn(mem_q[0]);
    end else begin
      bus.mem_resp_val  = 1'b0;
      bus.mem_resp_data = $urandom;
    end
    #1;
    has_head  = (outst.size() != 0);
    head_live = has_head && outst[0].live;
    e_req     = !r && !sq && (outst.size() < c_max);
    e_rdy     = r ? 1'b0 : ((sq || (has_head && !head_live)) ? 1'b1 : drdy);
    e_dval    = !r && !sq && bus.mem_resp_val && head_live;
    chk("mem_req_val", bus.mem_req_val, e_req);
    if (e_req) chk("mem_req_addr", bus.mem_req_addr, exp_pc);
    chk("mem_resp_rdy", bus.mem_resp_rdy, e_rdy);
    chk("d_val", bus.d_val, e_dval);
    if (e_dval) begin
      chk("d_pc", bus.d_pc, outst[0].addr);
      chk("d_inst", bus.d_inst, mem_fn(outst[0].addr));
    end
    // Advance the reference model.
    e_rxfer = bus.mem_resp_val && e_rdy;
    if (r) begin
      outst.delete();
      exp_pc = c_rst_addr;
    end else begin
      if (e_rxfer && has_head) void'(outst.pop_front());
      if (sq) begin
        foreach (outst[i]) outst[i].live = 1'b0;
        exp_pc = tgt;
      end else if (e_req && qrdy) begin
        outst.push_back(req_t'{addr: exp_pc, live: 1'b1});
        exp_pc = exp_pc + 32'd4;
      end
    end
    // Advance the memory environment from what the DUT actually did.
    if (r) begin
      mem_q.delete();
      hold = 1'b0;
    end else begin
      if (bus.mem_resp_val && bus.mem_resp_rdy) begin
        void'(mem_q.pop_front());
        hold = 1'b0;
      end else begin
        hold = bus.mem_resp_val;
      end
      if (bus.mem_req_val && bus.mem_req_rdy) mem_q.push_back(bus.mem_req_addr);
    end
  endtask

  task automatic rand_steps(input int n, input int sq_mod);
    for (int i = 0; i < n; i++) begin
      step(1'b0, $urandom_range(0, sq_mod - 1) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 32'd60);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.squash        = 1'b0;
    bus.branch_target = 32'h0;
    bus.d_rdy         = 1'b0;
    bus.mem_req_rdy   = 1'b0;
    bus.mem_resp_val  = 1'b0;
    bus.mem_resp_data = 32'h0;
    exp_pc            = c_rst_addr;
    hold              = 1'b0;

    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'd0);
    // Steady stream with everything ready.
    repeat (20) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd100);
    // Decode stall fills the window, then drains.
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'd100);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd100);
    // Redirect with responses outstanding.
    step(1'b0, 1'b1, 32'h0000_1000, 1'b1, 1'b1, 32'd100);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd100);
    // Back-to-back redirects.
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 32'd100);
    step(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1, 32'd100);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd100);
    // Address wrap past the top of memory.
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'd100);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'd100);
    // Random traffic, reset mid-operation, then more random traffic.
    rand_steps(2000, 10);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'd0);
    rand_steps(1500, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
